// File: rtl/nes_loader_pkg.sv
// Shared types and constants for the iNES ROM loader: FSM states, magic, unit sizes, error codes.
package nes_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_TRAINER,
    ST_PRG_BYTE,
    ST_CHR_BYTE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_IDLE,
    ST_DONE,
    ST_ERROR
  } state_t;

  // "NES\x1A", header byte 0 in bits [7:0]
  localparam logic [31:0] INES_MAGIC = 32'h1A53454E;

  localparam int unsigned PRG_UNIT_SIZE = 16384;
  localparam int unsigned CHR_UNIT_SIZE = 8192;
  localparam int unsigned TRAINER_LEN   = 512;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MAGIC    = 2'd1;
  localparam logic [1:0] ERR_PRG_SIZE = 2'd2;
  localparam logic [1:0] ERR_CHR_SIZE = 2'd3;

endpackage

// File: rtl/ines_header_parser.sv
// Walks the 16-byte iNES header: checks magic, captures size/flag fields, and
// flags ok/error combinationally on the accepting cycle of the deciding byte.
module ines_header_parser
  import nes_loader_pkg::*;
#(
  parameter int unsigned PRG_MAX_UNITS = 32,
  parameter int unsigned CHR_MAX_UNITS = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_accept,
  input  logic [7:0] i_data,
  output logic       o_hdr_ok,
  output logic       o_hdr_err,
  output logic [1:0] o_err_code,
  output logic [7:0] o_prg_units,
  output logic [7:0] o_chr_units,
  output logic [7:0] o_mapper,
  output logic       o_mirroring,
  output logic       o_four_screen,
  output logic       o_trainer
);

  localparam logic [7:0] PRG_MAX8 = 8'(PRG_MAX_UNITS);
  localparam logic [7:0] CHR_MAX8 = 8'(CHR_MAX_UNITS);

  logic [3:0] r_idx;
  logic [7:0] r_prg;
  logic [7:0] r_chr;
  logic [3:0] r_map_lo;
  logic [3:0] r_map_hi;
  logic       r_mirror;
  logic       r_four;
  logic       r_trainer;

  logic w_magic_bad;
  logic w_prg_bad;
  logic w_chr_bad;
  logic w_last;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_idx     <= '0;
      r_prg     <= '0;
      r_chr     <= '0;
      r_map_lo  <= '0;
      r_map_hi  <= '0;
      r_mirror  <= 1'b0;
      r_four    <= 1'b0;
      r_trainer <= 1'b0;
    end else if (i_accept) begin
      r_idx <= r_idx + 4'd1;
      case (r_idx)
        4'd4: r_prg <= i_data;
        4'd5: r_chr <= i_data;
        4'd6: begin
          r_map_lo  <= i_data[7:4];
          r_four    <= i_data[3];
          r_trainer <= i_data[2];
          r_mirror  <= i_data[0];
        end
        4'd7:    r_map_hi <= i_data[7:4];
        default: ;
      endcase
    end
  end

  assign w_magic_bad = (r_idx < 4'd4) && (i_data != INES_MAGIC[{r_idx[1:0], 3'b000} +: 8]);
  assign w_prg_bad   = (r_prg == 8'd0) || (r_prg > PRG_MAX8);
  assign w_chr_bad   = (r_chr > CHR_MAX8);
  assign w_last      = (r_idx == 4'd15);

  assign o_hdr_err = i_accept && (w_magic_bad || (w_last && (w_prg_bad || w_chr_bad)));
  assign o_hdr_ok  = i_accept && w_last && !w_prg_bad && !w_chr_bad;

  always_comb begin
    o_err_code = ERR_NONE;
    if (w_magic_bad)    o_err_code = ERR_MAGIC;
    else if (w_prg_bad) o_err_code = ERR_PRG_SIZE;
    else if (w_chr_bad) o_err_code = ERR_CHR_SIZE;
  end

  assign o_prg_units   = r_prg;
  assign o_chr_units   = r_chr;
  assign o_mapper      = {r_map_hi, r_map_lo};
  assign o_mirroring   = r_mirror;
  assign o_four_screen = r_four;
  assign o_trainer     = r_trainer;

endmodule

// File: rtl/nes_rom_loader.sv
// iNES image loader: parses the header, skips the trainer, and writes PRG/CHR
// bytes one at a time through the memory controller request interface.
module nes_rom_loader
  import nes_loader_pkg::*;
#(
  parameter int unsigned PRG_MAX_UNITS  = 32,
  parameter int unsigned CHR_MAX_UNITS  = 64,
  parameter logic [21:0] CHR_BASE       = 22'h200000,
  parameter logic [21:0] PRG_BASE       = 22'h000000,
  parameter int unsigned PRG_UNIT_BYTES = PRG_UNIT_SIZE,
  parameter int unsigned CHR_UNIT_BYTES = CHR_UNIT_SIZE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_write,
  output logic [21:0] mem_addr,
  output logic [7:0]  mem_din,
  input  logic        mem_busy,
  output logic        loading,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [7:0]  mapper,
  output logic        mirroring,
  output logic        four_screen,
  output logic        chr_ram,
  output logic [7:0]  prg_units
);

  state_t      r_state;
  logic [19:0] r_cnt;
  logic        r_in_chr;
  logic [21:0] r_addr;
  logic [7:0]  r_din;
  logic        r_loading;
  logic        r_done;
  logic        r_error;
  logic [1:0]  r_err_code;
  logic [7:0]  r_mapper;
  logic        r_mirroring;
  logic        r_four_screen;
  logic        r_chr_ram;
  logic [7:0]  r_prg_units;

  logic        w_accept;
  logic        w_start_ok;
  logic        w_hdr_ok;
  logic        w_hdr_err;
  logic [1:0]  w_err_code;
  logic [7:0]  w_prg_units;
  logic [7:0]  w_chr_units;
  logic [7:0]  w_mapper;
  logic        w_mirroring;
  logic        w_four_screen;
  logic        w_trainer;
  logic        w_chr_zero;
  logic [19:0] w_prg_last;
  logic [19:0] w_chr_last;
  logic        w_region_last;

  ines_header_parser #(
    .PRG_MAX_UNITS(PRG_MAX_UNITS),
    .CHR_MAX_UNITS(CHR_MAX_UNITS)
  ) u_hdr (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_start_ok),
    .i_accept     (w_accept && (r_state == ST_HDR)),
    .i_data       (in_data),
    .o_hdr_ok     (w_hdr_ok),
    .o_hdr_err    (w_hdr_err),
    .o_err_code   (w_err_code),
    .o_prg_units  (w_prg_units),
    .o_chr_units  (w_chr_units),
    .o_mapper     (w_mapper),
    .o_mirroring  (w_mirroring),
    .o_four_screen(w_four_screen),
    .o_trainer    (w_trainer)
  );

  assign in_ready = (r_state == ST_HDR) || (r_state == ST_TRAINER) ||
                    (r_state == ST_PRG_BYTE) || (r_state == ST_CHR_BYTE);
  assign w_accept   = in_valid && in_ready;
  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR));

  assign w_chr_zero    = (w_chr_units == 8'd0);
  assign w_prg_last    = 20'(32'(w_prg_units) * PRG_UNIT_BYTES - 32'd1);
  assign w_chr_last    = 20'(32'(w_chr_units) * CHR_UNIT_BYTES - 32'd1);
  assign w_region_last = r_in_chr ? (r_cnt == w_chr_last) : (r_cnt == w_prg_last);

  // Gated by the live busy flag so a request is never presented while the controller is occupied.
  assign mem_write = (r_state == ST_ISSUE) && !mem_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_in_chr      <= 1'b0;
      r_addr        <= '0;
      r_din         <= '0;
      r_loading     <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_err_code    <= ERR_NONE;
      r_mapper      <= '0;
      r_mirroring   <= 1'b0;
      r_four_screen <= 1'b0;
      r_chr_ram     <= 1'b0;
      r_prg_units   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
            r_cnt      <= '0;
            r_in_chr   <= 1'b0;
            r_loading  <= 1'b1;
            r_state    <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (w_hdr_err) begin
            r_err_code <= w_err_code;
            r_error    <= 1'b1;
            r_loading  <= 1'b0;
            r_state    <= ST_ERROR;
          end else if (w_hdr_ok) begin
            r_cnt   <= '0;
            r_state <= w_trainer ? ST_TRAINER : ST_PRG_BYTE;
          end
        end
        ST_TRAINER: begin
          if (w_accept) begin
            if (r_cnt == 20'(TRAINER_LEN - 1)) begin
              r_cnt   <= '0;
              r_state <= ST_PRG_BYTE;
            end else begin
              r_cnt <= r_cnt + 20'd1;
            end
          end
        end
        ST_PRG_BYTE, ST_CHR_BYTE: begin
          if (w_accept) begin
            r_din   <= in_data;
            r_addr  <= (r_in_chr ? CHR_BASE : PRG_BASE) + {2'b00, r_cnt};
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!mem_busy) r_state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (mem_busy) r_state <= ST_WAIT_IDLE;
        end
        ST_WAIT_IDLE: begin
          if (!mem_busy) begin
            if (!w_region_last) begin
              r_cnt   <= r_cnt + 20'd1;
              r_state <= r_in_chr ? ST_CHR_BYTE : ST_PRG_BYTE;
            end else if (!r_in_chr && !w_chr_zero) begin
              r_cnt    <= '0;
              r_in_chr <= 1'b1;
              r_state  <= ST_CHR_BYTE;
            end else begin
              r_done        <= 1'b1;
              r_loading     <= 1'b0;
              r_mapper      <= w_mapper;
              r_mirroring   <= w_mirroring;
              r_four_screen <= w_four_screen;
              r_chr_ram     <= w_chr_zero;
              r_prg_units   <= w_prg_units;
              r_state       <= ST_DONE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_addr    = r_addr;
  assign mem_din     = r_din;
  assign loading     = r_loading;
  assign done        = r_done;
  assign error       = r_error;
  assign err_code    = r_err_code;
  assign mapper      = r_mapper;
  assign mirroring   = r_mirroring;
  assign four_screen = r_four_screen;
  assign chr_ram     = r_chr_ram;
  assign prg_units   = r_prg_units;

endmodule

// File: tb/tb_nes_rom_loader.sv
// Testbench for nes_rom_loader: streams iNES images into the loader against a
// 3-cycle-busy controller model and scoreboards every write request.
`timescale 1ns/1ps
module tb_nes_rom_loader;

  // Unit sizes shrunk so whole images load in a few thousand cycles.
  localparam int unsigned PRG_UB = 256;
  localparam int unsigned CHR_UB = 128;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mem_write;
  logic [21:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_busy;
  logic        loading;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [7:0]  mapper;
  logic        mirroring;
  logic        four_screen;
  logic        chr_ram;
  logic [7:0]  prg_units;

  logic        ctl_busy = 1'b0;
  int          ctl_cnt = 0;
  logic        ext_busy = 1'b0;
  logic        prev_write = 1'b0;
  logic [29:0] exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          n_writes = 0;
  int          g_sent = 0;

  assign mem_busy = ctl_busy | ext_busy;

  always #5 clk = ~clk;

  nes_rom_loader #(
    .PRG_MAX_UNITS (32),
    .CHR_MAX_UNITS (64),
    .CHR_BASE      (22'h200000),
    .PRG_BASE      (22'h000000),
    .PRG_UNIT_BYTES(PRG_UB),
    .CHR_UNIT_BYTES(CHR_UB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_busy   (mem_busy),
    .loading    (loading),
    .done       (done),
    .error      (error),
    .err_code   (err_code),
    .mapper     (mapper),
    .mirroring  (mirroring),
    .four_screen(four_screen),
    .chr_ram    (chr_ram),
    .prg_units  (prg_units)
  );

  // Controller: captures a request on the edge and stays busy for 3 cycles.
  always @(posedge clk) begin
    if (mem_write) begin
      ctl_busy <= 1'b1;
      ctl_cnt  <= 3;
    end else if (ctl_cnt > 1) begin
      ctl_cnt <= ctl_cnt - 1;
    end else begin
      ctl_cnt  <= 0;
      ctl_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mem_write) begin
      logic [29:0] e;
      n_writes++;
      n_total++;
      if (prev_write !== 1'b0 || mem_busy !== 1'b0)
        $display("FAIL write_pulse t=%0t prev_write=%b busy=%b required 0/0", $time, prev_write, mem_busy);
      else
        n_pass++;
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL write_unexpected t=%0t addr=%h data=%h required no write", $time, mem_addr, mem_din);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_din} !== e)
          $display("FAIL write_data t=%0t addr=%h data=%h required addr=%h data=%h",
                   $time, mem_addr, mem_din, e[29:8], e[7:0]);
        else
          n_pass++;
      end
    end
    prev_write = mem_write;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic build_image(input logic [7:0] prg, input logic [7:0] chr, input logic [7:0] f6,
                             input logic [7:0] f7, input bit with_body, input bit push_exp,
                             output byte_q_t img);
    logic [7:0] d;
    img = {};
    img.push_back(8'h4E); img.push_back(8'h45); img.push_back(8'h53); img.push_back(8'h1A);
    img.push_back(prg); img.push_back(chr); img.push_back(f6); img.push_back(f7);
    repeat (8) img.push_back(8'h00);
    if (with_body) begin
      if (f6[2]) repeat (512) img.push_back(8'($urandom));
      for (int i = 0; i < int'(prg) * int'(PRG_UB); i++) begin
        d = 8'($urandom);
        img.push_back(d);
        if (push_exp) exp_q.push_back({22'h000000 + 22'(i), d});
      end
      for (int i = 0; i < int'(chr) * int'(CHR_UB); i++) begin
        d = 8'($urandom);
        img.push_back(d);
        if (push_exp) exp_q.push_back({22'h200000 + 22'(i), d});
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic feed(input byte_q_t img, input int from, input int upto, input bit gaps, input int max_cycles);
    int i = from;
    int cyc = 0;
    g_sent = 0;
    while (i < upto && cyc < max_cycles) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = img[i];
      if (in_valid && in_ready) begin
        i++;
        g_sent++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic wait_end(input int max_cycles, output bit ok);
    int c = 0;
    while (!(done || error) && c < max_cycles) begin
      @(negedge clk);
      c++;
    end
    ok = done || error;
  endtask

  task automatic test_reset();
    logic [55:0] v;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    v = {in_ready, mem_write, mem_addr, mem_din, loading, done, error, err_code,
         mapper, mirroring, four_screen, chr_ram, prg_units};
    n_total++;
    if (v !== 56'h0) $display("FAIL reset_outputs got=%h required=0", v); else n_pass++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    v = {in_ready, mem_write, mem_addr, mem_din, loading, done, error, err_code,
         mapper, mirroring, four_screen, chr_ram, prg_units};
    n_total++;
    if (v !== 56'h0) $display("FAIL idle_outputs got=%h required=0", v); else n_pass++;
  endtask

  task automatic test_basic();
    byte_q_t img;
    bit ok;
    exp_q.delete();
    n_writes = 0;
    build_image(8'd2, 8'd1, 8'h01, 8'h10, 1'b1, 1'b1, img);
    pulse_start();
    n_total++;
    if ({loading, in_ready} !== 2'b11) $display("FAIL basic_start got=%b required=11", {loading, in_ready}); else n_pass++;
    feed(img, 0, img.size(), 1'b0, 20000);
    n_total++;
    if (g_sent !== img.size()) $display("FAIL basic_consumed got=%0d required=%0d", g_sent, img.size()); else n_pass++;
    wait_end(100, ok);
    n_total++;
    if (!ok) $display("FAIL basic_timeout got=no end required=done"); else n_pass++;
    n_total++;
    if ({done, error, loading, in_ready} !== 4'b1000)
      $display("FAIL basic_status got=%b required=1000", {done, error, loading, in_ready}); else n_pass++;
    n_total++;
    if ({mapper, mirroring, four_screen, chr_ram, prg_units} !== {8'h10, 1'b1, 1'b0, 1'b0, 8'd2})
      $display("FAIL basic_config got=%h/%b/%b/%b/%0d required=10/1/0/0/2",
               mapper, mirroring, four_screen, chr_ram, prg_units); else n_pass++;
    n_total++;
    if (n_writes !== 640) $display("FAIL basic_write_count got=%0d required=640", n_writes); else n_pass++;
    n_total++;
    if (exp_q.size() !== 0) $display("FAIL basic_missing got=%0d left required=0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_bad_magic();
    byte_q_t img;
    exp_q.delete();
    n_writes = 0;
    build_image(8'd1, 8'd0, 8'h00, 8'h00, 1'b0, 1'b0, img);
    img[2] = 8'h54;
    repeat (4) img.push_back(8'hAA);
    pulse_start();
    feed(img, 0, img.size(), 1'b0, 40);
    n_total++;
    if (g_sent !== 3) $display("FAIL magic_consumed got=%0d required=3", g_sent); else n_pass++;
    n_total++;
    if ({error, err_code, done, loading, in_ready} !== 6'b101000)
      $display("FAIL magic_status got=%b required=101000", {error, err_code, done, loading, in_ready}); else n_pass++;
    n_total++;
    if (n_writes !== 0) $display("FAIL magic_writes got=%0d required=0", n_writes); else n_pass++;
  endtask

  task automatic test_size_errors();
    logic [7:0] tp[3] = '{8'd33, 8'd0, 8'd1};
    logic [7:0] tc[3] = '{8'd1, 8'd1, 8'd65};
    logic [1:0] te[3] = '{2'd2, 2'd2, 2'd3};
    byte_q_t img;
    for (int k = 0; k < 3; k++) begin
      exp_q.delete();
      n_writes = 0;
      build_image(tp[k], tc[k], 8'h00, 8'h00, 1'b0, 1'b0, img);
      repeat (4) img.push_back(8'h55);
      pulse_start();
      feed(img, 0, img.size(), 1'b0, 40);
      n_total++;
      if (g_sent !== 16) $display("FAIL size%0d_consumed got=%0d required=16", k, g_sent); else n_pass++;
      n_total++;
      if ({error, err_code, loading, in_ready, n_writes == 0} !== {1'b1, te[k], 1'b0, 1'b0, 1'b1})
        $display("FAIL size%0d_status got=%b/%0d/%b/%b writes=%0d required=1/%0d/0/0 writes=0",
                 k, error, err_code, loading, in_ready, n_writes, te[k]); else n_pass++;
    end
  endtask

  task automatic test_size_boundary();
    byte_q_t img;
    exp_q.delete();
    build_image(8'd32, 8'd64, 8'h00, 8'h00, 1'b0, 1'b0, img);
    pulse_start();
    feed(img, 0, img.size(), 1'b0, 40);
    repeat (2) @(negedge clk);
    n_total++;
    if ({error, loading, in_ready} !== 3'b011)
      $display("FAIL size_max_accept got=%b required=011", {error, loading, in_ready}); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_trainer();
    byte_q_t img;
    bit ok;
    exp_q.delete();
    n_writes = 0;
    build_image(8'd1, 8'd0, 8'h04, 8'h00, 1'b1, 1'b1, img);
    pulse_start();
    feed(img, 0, 528, 1'b0, 2000);
    repeat (3) @(negedge clk);
    n_total++;
    if ({g_sent == 528, n_writes == 0, loading, in_ready} !== 4'b1111)
      $display("FAIL trainer_skip sent=%0d writes=%0d loading=%b ready=%b required 528/0/1/1",
               g_sent, n_writes, loading, in_ready); else n_pass++;
    feed(img, 528, img.size(), 1'b0, 20000);
    wait_end(100, ok);
    n_total++;
    if (!ok || {done, error} !== 2'b10) $display("FAIL trainer_end got=%b required=10", {done, error}); else n_pass++;
    n_total++;
    if ({chr_ram, mirroring, mapper, prg_units} !== {1'b1, 1'b0, 8'h00, 8'd1})
      $display("FAIL trainer_config got=%b/%b/%h/%0d required=1/0/00/1", chr_ram, mirroring, mapper, prg_units); else n_pass++;
    n_total++;
    if (n_writes !== 256 || exp_q.size() !== 0)
      $display("FAIL trainer_writes got=%0d left=%0d required=256 left=0", n_writes, exp_q.size()); else n_pass++;
  endtask

  task automatic test_busy_random();
    byte_q_t img;
    bit ok;
    exp_q.delete();
    n_writes = 0;
    build_image(8'd1, 8'd1, 8'h00, 8'h00, 1'b1, 1'b1, img);
    ext_busy = 1'b1;
    g_sent = 0;
    pulse_start();
    fork
      feed(img, 0, img.size(), 1'b1, 30000);
      begin
        int k = 0;
        while (g_sent < 17 && k < 1000) begin
          @(negedge clk);
          k++;
        end
        n_total++;
        if (g_sent < 17) $display("FAIL busy_first_byte got=%0d required>=17", g_sent); else n_pass++;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          n_total++;
          if (mem_write !== 1'b0 || n_writes !== 0)
            $display("FAIL busy_hold cycle=%0d write=%b writes=%0d required 0/0", c, mem_write, n_writes);
          else
            n_pass++;
        end
        ext_busy = 1'b0;
      end
    join
    wait_end(100, ok);
    n_total++;
    if (!ok || {done, error} !== 2'b10) $display("FAIL busy_end got=%b required=10", {done, error}); else n_pass++;
    n_total++;
    if (n_writes !== 384 || exp_q.size() !== 0)
      $display("FAIL busy_writes got=%0d left=%0d required=384 left=0", n_writes, exp_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    byte_q_t img;
    bit ok;
    int k;
    logic [55:0] v;
    exp_q.delete();
    n_writes = 0;
    build_image(8'd1, 8'd0, 8'h00, 8'h00, 1'b1, 1'b1, img);
    pulse_start();
    feed(img, 0, 116, 1'b0, 5000);
    k = 0;
    while (n_writes < 100 && k < 50) begin
      @(negedge clk);
      k++;
    end
    n_total++;
    if (n_writes !== 100) $display("FAIL midreset_progress got=%0d required=100", n_writes); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    v = {in_ready, mem_write, mem_addr, mem_din, loading, done, error, err_code,
         mapper, mirroring, four_screen, chr_ram, prg_units};
    n_total++;
    if (v !== 56'h0) $display("FAIL midreset_outputs got=%h required=0", v); else n_pass++;
    reset = 1'b0;
    exp_q.delete();
    repeat (5) @(negedge clk);
    n_writes = 0;
    build_image(8'd1, 8'd1, 8'h09, 8'hA0, 1'b1, 1'b1, img);
    pulse_start();
    feed(img, 0, img.size(), 1'b0, 20000);
    wait_end(100, ok);
    n_total++;
    if (!ok || {done, error} !== 2'b10) $display("FAIL reload_end got=%b required=10", {done, error}); else n_pass++;
    n_total++;
    if ({mapper, mirroring, four_screen, chr_ram, prg_units} !== {8'hA0, 1'b1, 1'b1, 1'b0, 8'd1})
      $display("FAIL reload_config got=%h/%b/%b/%b/%0d required=A0/1/1/0/1",
               mapper, mirroring, four_screen, chr_ram, prg_units); else n_pass++;
    n_total++;
    if (n_writes !== 384 || exp_q.size() !== 0)
      $display("FAIL reload_writes got=%0d left=%0d required=384 left=0", n_writes, exp_q.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_magic();
    test_size_errors();
    test_size_boundary();
    test_trainer();
    test_busy_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nes_rom_loader.md
Name: nes_rom_loader

Overview:
- Initiator on the write side of the SRAM/BRAM memory controller's request interface.
- Consumes an iNES image as a byte stream from the SD/SPI front-end, parses and checks the 16-byte header, and skips the optional 512-byte trainer.
- Issues one byte write per request: PRG data to the PRG ROM region, CHR data to the CHR ROM region.
- Holds the memory bus, via `loading`, until the image is complete; then publishes the mapper/mirroring configuration to the NES core.

Parameters:
- PRG_MAX_UNITS, 32, maximum PRG size in 16 KB units (512 KB SRAM half).
- CHR_MAX_UNITS, 64, maximum CHR size in 8 KB units (512 KB SRAM half).
- CHR_BASE, 22'h200000, base address of the CHR region (addr[21:20]=2'b10).
- PRG_BASE, 22'h000000, base address of the PRG region.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR
- in_valid  in  1  stream byte valid
- in_data  in  8  stream byte
- in_ready  out  1  byte accepted on a clk edge where in_valid && in_ready
- mem_write  out  1  write request to the memory controller
- mem_addr  out  22  request address
- mem_din  out  8  request data
- mem_busy  in  1  controller busy flag
- loading  out  1  high from start until DONE/ERROR; the top level muxes the bus to this block while it is high
- done  out  1  image loaded, configuration outputs valid
- error  out  1  load aborted
- err_code  out  2  0 none, 1 bad magic, 2 PRG too large / zero, 3 CHR too large
- mapper  out  8  {byte7[7:4], byte6[7:4]}
- mirroring  out  1  byte6[0]
- four_screen  out  1  byte6[3]
- chr_ram  out  1  CHR size byte == 0
- prg_units  out  8  header byte 4

Behaviour:
- Reset values: all outputs 0, state IDLE. Reset mid-load drops mem_write the same edge; a controller access already in flight completes unobserved.
- States: IDLE, HDR, TRAINER, PRG_BYTE, CHR_BYTE, ISSUE, WAIT_BUSY, WAIT_IDLE, DONE, ERROR.
- IDLE/DONE/ERROR:
  - start clears done, error and err_code, and the counters.
  - Sets loading=1 and enters HDR.
  - start in any other state is ignored.
- HDR:
  - in_ready=1; accepts 16 bytes, header index 0..15.
  - Bytes 0..3 must equal 4E 45 53 1A; a mismatch at any of these bytes goes to ERROR (code 1) on that byte.
  - After byte 15, the size checks run:
    - PRG == 0 or PRG > PRG_MAX_UNITS → ERROR code 2.
    - CHR > CHR_MAX_UNITS → ERROR code 3.
  - If the checks pass, go to TRAINER if byte6[2], else PRG_BYTE.
- TRAINER: accepts and discards exactly 512 bytes, then PRG_BYTE.
- PRG_BYTE / CHR_BYTE:
  - in_ready=1.
  - On accept, latch mem_din, set mem_addr = base + byte count, go to ISSUE.
  - in_ready is 0 in every other state.
- ISSUE:
  - mem_write=1 for exactly one cycle, and only if mem_busy==0; otherwise wait in ISSUE with mem_write=0.
  - Then go to WAIT_BUSY.
- WAIT_BUSY: wait for mem_busy==1 (the controller raises busy the edge after capture), then go to WAIT_IDLE.
- WAIT_IDLE:
  - Wait for mem_busy==0, then increment the 20-bit byte counter.
  - The last byte of a region is at counter == units*16384-1 for PRG, units*8192-1 for CHR.
  - After the last PRG byte, go to CHR_BYTE, or to DONE if chr_ram.
  - After the last CHR byte, go to DONE.
- mem_write is never high in two consecutive cycles; mem_addr and mem_din are stable from ISSUE until WAIT_IDLE exits.
- Per-byte throughput: 1 accept + 1 issue + busy duration (3 cycles) + 1 cycles.
- DONE: loading=0, done=1 held; mapper, mirroring and related outputs are stable from the same edge.
- ERROR: loading=0, error=1 held, remaining stream bytes not accepted (in_ready=0).
- Address arithmetic is 20-bit offset plus base; no wrap is possible because the size checks bound the offset.
- Extra bytes after the image (e.g. PlayChoice data) are not consumed; in_ready stays 0 in DONE.

Decomposition:
- Package nes_loader_pkg holds:
  - the state enum;
  - the iNES magic bytes;
  - PRG/CHR unit sizes (16384/8192);
  - the trainer length 512;
  - the err_code constants.
- One sub-module is natural: ines_header_parser (byte index, magic check, field capture, size checks, one-cycle hdr_ok/hdr_err pulse).

Test Plan:
- Header PRG=2, CHR=1, flags6=0x01, flags7=0x10, stream fed continuously:
  - writes land at 0x000000..0x007FFF then 0x200000..0x201FFF;
  - 40960 mem_write pulses total;
  - done=1, mapper=0x10, mirroring=1, chr_ram=0.
- Header byte 2 = 0x54: ERROR code 1 on that byte, no mem_write ever asserted, in_ready=0 afterwards.
- Trainer bit set, PRG=1, CHR=0:
  - 512 trainer bytes consumed with no writes;
  - first PRG write carries the 529th byte at addr 0x000000;
  - ends DONE with chr_ram=1 and 16384 writes.
- PRG=33: ERROR code 2 after byte 15. CHR=65 with PRG=1: ERROR code 3.
- Controller busy held high 10 cycles before the first issue, and in_valid toggled randomly:
  - no mem_write while mem_busy=1;
  - each write pulse is 1 cycle;
  - data and address sequence are unchanged.
- reset asserted mid-PRG (byte 100):
  - all outputs 0 next cycle;
  - a new start with a fresh image loads correctly from address 0.
